// File: rtl/stebus_cycle_ctrl_if.sv
// stebus_cycle_ctrl_if: CPU-side and STEbus-side signals of the cycle controller.
// Inputs to the controller: sel, mreq, iorq, m1, rd, wr, datack, trferr (all active-low), err_clr.
// Outputs of the controller: cm[2:0], strobe (DATSTB, active-low), zwait (active-low), busy, err_trf, err_to.
interface stebus_cycle_ctrl_if;
    logic       sel;
    logic       mreq;
    logic       iorq;
    logic       m1;
    logic       rd;
    logic       wr;
    logic       datack;
    logic       trferr;
    logic       err_clr;
    logic [2:0] cm;
    logic       strobe;
    logic       zwait;
    logic       busy;
    logic       err_trf;
    logic       err_to;
    modport master (
        output sel, mreq, iorq, m1, rd, wr, datack, trferr, err_clr,
        input  cm, strobe, zwait, busy, err_trf, err_to
    );
    modport slave (
        input  sel, mreq, iorq, m1, rd, wr, datack, trferr, err_clr,
        output cm, strobe, zwait, busy, err_trf, err_to
    );
endinterface

// File: rtl/stebus_cycle_ctrl.sv
// stebus_cycle_ctrl: runs one STEbus master transfer per Z180 access steered to the bus window.
// Ports: clk, rst (async, active-high); bus (slave modport) carries the Z180 strobes, window select,
// DATACK/TRFERR, err_clr and drives cm[2:0], DATSTB, WAIT, busy and the sticky error flags.
module stebus_cycle_ctrl #(
    parameter int SETUP_CYCLES   = 1,
    parameter int TIMEOUT_CYCLES = 255,
    parameter int HOLD_CYCLES    = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    stebus_cycle_ctrl_if.slave   bus
);
    typedef enum logic [2:0] {IDLE, SETUP, STROBE, RELEASE, DONE} state_t;
    localparam logic [7:0] SETUP_LD = 8'(SETUP_CYCLES - 1);
    localparam logic [7:0] TO_LD    = 8'(TIMEOUT_CYCLES - 1);
    // A zero hold still spends one clock in RELEASE.
    localparam logic [7:0] HOLD_LD  = 8'((HOLD_CYCLES > 0) ? HOLD_CYCLES - 1 : 0);
    state_t     r_state, w_next;
    logic [7:0] r_cnt, w_cnt;
    logic [2:0] r_cm, w_cm, w_dec;
    logic       r_err_trf, r_err_to, w_set_trf, w_set_to;
    logic       w_start, w_read;
    assign w_start = !bus.sel & ((!bus.mreq & (!bus.rd | !bus.wr)) |
                                 (!bus.iorq & (!bus.rd | !bus.wr | !bus.m1)));
    // rd and wr both low is treated as a read.
    assign w_read  = !bus.rd;
    assign w_dec   = !bus.mreq ? {2'b11, w_read} :
                     (!bus.iorq & !bus.m1) ? 3'b001 : {2'b01, w_read};
    always_comb begin
        w_next    = r_state;
        w_cnt     = r_cnt;
        w_cm      = r_cm;
        w_set_trf = 1'b0;
        w_set_to  = 1'b0;
        case (r_state)
            IDLE: if (w_start) begin
                w_next = SETUP;
                w_cnt  = SETUP_LD;
                w_cm   = w_dec;
            end
            SETUP: if (!w_start) w_next = DONE;
            else if (r_cnt == 8'd0) begin
                w_next = STROBE;
                w_cnt  = TO_LD;
            end else w_cnt = r_cnt - 8'd1;
            // A withdrawn CPU cycle beats any bus response; TRFERR beats DATACK.
            STROBE: if (!w_start) w_next = DONE;
            else if (!bus.trferr) begin
                w_set_trf = 1'b1;
                w_next    = RELEASE;
                w_cnt     = HOLD_LD;
            end else if (!bus.datack) begin
                w_next = RELEASE;
                w_cnt  = HOLD_LD;
            end else if (r_cnt == 8'd0) begin
                w_set_to = 1'b1;
                w_next   = RELEASE;
                w_cnt    = HOLD_LD;
            end else w_cnt = r_cnt - 8'd1;
            RELEASE: if (r_cnt == 8'd0) w_next = DONE;
            else w_cnt = r_cnt - 8'd1;
            // Stay here until the CPU ends its cycle so one access makes one transfer.
            DONE: if (bus.mreq & bus.iorq) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_cm      <= '0;
            r_err_trf <= 1'b0;
            r_err_to  <= 1'b0;
        end else begin
            r_state   <= w_next;
            r_cnt     <= w_cnt;
            r_cm      <= w_cm;
            r_err_trf <= w_set_trf | (r_err_trf & !bus.err_clr);
            r_err_to  <= w_set_to | (r_err_to & !bus.err_clr);
        end
    end
    assign bus.cm      = (r_state == SETUP || r_state == STROBE || r_state == RELEASE) ? r_cm : 3'b000;
    assign bus.strobe  = r_state != STROBE;
    // WAIT goes low in the same clock the request appears; reset forces it high.
    assign bus.zwait   = rst | !((r_state == IDLE && w_start) || r_state == SETUP || r_state == STROBE);
    assign bus.busy    = r_state != IDLE;
    assign bus.err_trf = r_err_trf;
    assign bus.err_to  = r_err_to;
endmodule

// File: tb/tb_stebus_cycle_ctrl.sv
// tb_stebus_cycle_ctrl: directed and randomized checks of stebus_cycle_ctrl against a transaction model.
module tb_stebus_cycle_ctrl;
    localparam int SETUP = 1, TMO = 8, HOLD = 1;
    localparam int HOLD_EFF = (HOLD > 0) ? HOLD : 1;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int total = 0, bad = 0;
    int n_low = 0, n_fall = 0;
    logic prev_stb = 1'b1;
    stebus_cycle_ctrl_if bus();
    stebus_cycle_ctrl #(.SETUP_CYCLES(SETUP), .TIMEOUT_CYCLES(TMO), .HOLD_CYCLES(HOLD)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );
    always #5 clk = ~clk;
    task automatic chk(string name, logic [7:0] got, logic [7:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h at %0t", name, got, exp, $time);
        end
    endtask
    function automatic logic start_f();
        return !bus.sel && ((!bus.mreq && (!bus.rd || !bus.wr)) ||
                            (!bus.iorq && (!bus.rd || !bus.wr || !bus.m1)));
    endfunction
    task automatic req(logic s, logic mq, logic io, logic m, logic r, logic w);
        bus.sel = s; bus.mreq = mq; bus.iorq = io; bus.m1 = m; bus.rd = r; bus.wr = w;
    endtask
    task automatic idle_bus();
        req(1, 1, 1, 1, 1, 1);
    endtask
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    // Transaction model: m_k counts clocks spent in setup+strobe, m_rk clocks spent in release.
    logic       m_act, m_done, m_rel, m_et, m_eo;
    logic [2:0] m_cmd;
    int         m_k, m_rk;
    always @(posedge clk or posedge rst) begin
        logic st, so;
        st = 1'b0;
        so = 1'b0;
        if (rst) begin
            m_act <= 0; m_done <= 0; m_rel <= 0; m_k <= 0; m_rk <= 0; m_cmd <= 0; m_et <= 0; m_eo <= 0;
        end else begin
            if (!m_act) begin
                if (start_f()) begin
                    m_act <= 1; m_done <= 0; m_rel <= 0; m_k <= 0; m_rk <= 0;
                    m_cmd <= (!bus.iorq && !bus.m1) ? 3'b001 : {!bus.mreq, 1'b1, !bus.rd};
                end
            end else if (m_done) begin
                if (bus.mreq && bus.iorq) m_act <= 0;
            end else if (m_rel) begin
                if (m_rk + 1 >= HOLD_EFF) m_done <= 1;
                m_rk <= m_rk + 1;
            end else if (!start_f()) m_done <= 1;
            else if (m_k < SETUP) m_k <= m_k + 1;
            else if (!bus.trferr) begin st = 1; m_rel <= 1; m_rk <= 0; end
            else if (!bus.datack) begin m_rel <= 1; m_rk <= 0; end
            else if (m_k - SETUP + 1 == TMO) begin so = 1; m_rel <= 1; m_rk <= 0; end
            else m_k <= m_k + 1;
            m_et <= st | (m_et & !bus.err_clr);
            m_eo <= so | (m_eo & !bus.err_clr);
        end
    end
    always @(negedge clk) begin
        logic [2:0] e_cm;
        logic e_stb, e_zw;
        e_cm = 3'b000;
        e_stb = 1'b1;
        e_zw = !(!rst && !m_act && start_f());
        if (m_act && !m_done) begin
            e_cm = m_cmd;
            if (!m_rel) begin
                e_zw = 1'b0;
                if (m_k >= SETUP) e_stb = 1'b0;
            end
        end
        chk("m_cm", bus.cm, e_cm);
        chk("m_strobe", bus.strobe, e_stb);
        chk("m_zwait", bus.zwait, e_zw);
        chk("m_busy", bus.busy, m_act);
        chk("m_err_trf", bus.err_trf, m_et);
        chk("m_err_to", bus.err_to, m_eo);
        n_low <= n_low + (bus.strobe ? 0 : 1);
        n_fall <= n_fall + ((prev_stb && !bus.strobe) ? 1 : 0);
        prev_stb <= bus.strobe;
    end
    initial begin
        int bl, bf;
        idle_bus();
        bus.datack = 1; bus.trferr = 1; bus.err_clr = 0;
        tick(); tick();
        @(negedge clk);
        chk("rst_cm", bus.cm, 3'b000); chk("rst_strobe", bus.strobe, 1); chk("rst_zwait", bus.zwait, 1);
        chk("rst_busy", bus.busy, 0); chk("rst_errs", {bus.err_trf, bus.err_to}, 2'b00);
        tick(); rst = 0; tick();
        // I/O read, ack on third strobe clock
        bl = n_low; bf = n_fall;
        req(0, 1, 0, 1, 0, 1);
        @(negedge clk); chk("io_req_zwait", bus.zwait, 0);
        tick(); @(negedge clk); chk("io_setup_cm", bus.cm, 3'b011); chk("io_setup_stb", bus.strobe, 1);
        tick(); @(negedge clk); chk("io_stb1", bus.strobe, 0);
        tick(); tick(); bus.datack = 0;
        @(negedge clk); chk("io_stb3_zwait", bus.zwait, 0);
        tick(); bus.datack = 1;
        @(negedge clk); chk("io_rel_zwait", bus.zwait, 1); chk("io_rel_cm", bus.cm, 3'b011);
        tick(); idle_bus();
        @(negedge clk); chk("io_done_cm", bus.cm, 3'b000); chk("io_done_busy", bus.busy, 1);
        tick(); chk("io_low_clks", 8'(n_low - bl), 3); chk("io_pulses", 8'(n_fall - bf), 1);
        @(negedge clk); chk("io_idle_busy", bus.busy, 0); chk("io_errs", {bus.err_trf, bus.err_to}, 2'b00);
        tick();
        // Mem write, never acknowledged
        bl = n_low;
        req(0, 0, 1, 1, 1, 0);
        repeat (11) tick();
        chk("to_low_clks", 8'(n_low - bl), TMO);
        @(negedge clk); chk("to_err", bus.err_to, 1); chk("to_zwait", bus.zwait, 1); chk("to_cm", bus.cm, 3'b000);
        tick(); idle_bus(); bus.err_clr = 1;
        tick(); bus.err_clr = 0;
        @(negedge clk); chk("to_clr", bus.err_to, 0);
        tick();
        // Interrupt ack with TRFERR and DATACK together
        req(0, 1, 0, 0, 1, 1);
        tick(); @(negedge clk); chk("ia_cm", bus.cm, 3'b001);
        tick(); bus.trferr = 0; bus.datack = 0;
        tick(); bus.trferr = 1; bus.datack = 1; idle_bus();
        @(negedge clk); chk("ia_err_trf", bus.err_trf, 1); chk("ia_err_to", bus.err_to, 0);
        tick(); tick(); bus.err_clr = 1; tick(); bus.err_clr = 0; tick();
        // CPU withdraws during setup, then a fresh transfer
        bf = n_fall;
        req(0, 0, 1, 1, 0, 1);
        tick(); idle_bus();
        tick(); @(negedge clk); chk("ab_done_busy", bus.busy, 1); chk("ab_done_cm", bus.cm, 3'b000);
        tick(); @(negedge clk); chk("ab_idle", bus.busy, 0); chk("ab_errs", {bus.err_trf, bus.err_to}, 2'b00);
        chk("ab_no_pulse", 8'(n_fall - bf), 0);
        req(0, 0, 1, 1, 0, 1);
        tick(); @(negedge clk); chk("ab_new_cm", bus.cm, 3'b111);
        tick(); bus.datack = 0; @(negedge clk); chk("ab_new_stb", bus.strobe, 0);
        tick(); bus.datack = 1; idle_bus();
        tick(); tick(); chk("ab_new_pulse", 8'(n_fall - bf), 1);
        // Asynchronous reset while strobe is low
        req(0, 1, 0, 1, 1, 0);
        tick(); tick(); #2 rst = 1; #1;
        chk("ar_strobe", bus.strobe, 1); chk("ar_zwait", bus.zwait, 1);
        chk("ar_cm", bus.cm, 3'b000); chk("ar_busy", bus.busy, 0);
        idle_bus(); tick(); rst = 0; tick();
        // Request held in DONE
        bf = n_fall;
        req(0, 0, 1, 1, 0, 1);
        tick(); tick(); bus.datack = 0; tick(); bus.datack = 1; tick();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); chk("hd_busy", bus.busy, 1); chk("hd_cm", bus.cm, 3'b000); tick();
        end
        chk("hd_pulses", 8'(n_fall - bf), 1);
        idle_bus(); tick(); @(negedge clk); chk("hd_idle", bus.busy, 0);
        tick();
        // Randomized traffic
        for (int n = 0; n < 300; n++) begin
            int p, len, dp;
            p = $urandom_range(0, 8); len = $urandom_range(1, 25); dp = $urandom_range(0, 3);
            case (p)
                0: req(0, 0, 1, 1, 0, 1);
                1: req(0, 0, 1, 1, 1, 0);
                2: req(0, 1, 0, 1, 0, 1);
                3: req(0, 1, 0, 1, 1, 0);
                4: req(0, 1, 0, 0, 1, 1);
                5: req(0, 0, 1, 1, 0, 0);
                6: req(0, 0, 1, 0, 0, 1);
                7: req(1, 0, 1, 1, 0, 1);
                default: req(0, 0, 1, 1, 1, 1);
            endcase
            for (int c = 0; c < len; c++) begin
                bus.datack = !($urandom_range(0, 7) < dp);
                bus.trferr = ($urandom_range(0, 15) != 0);
                bus.err_clr = ($urandom_range(0, 9) == 0);
                if ($urandom_range(0, 199) == 0) begin
                    #2 rst = 1; #1 rst = 0;
                end
                tick();
            end
            idle_bus(); bus.datack = 1; bus.trferr = 1; bus.err_clr = 0;
            repeat ($urandom_range(1, 3)) tick();
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/stebus_cycle_ctrl.md
Name: stebus_cycle_ctrl

Overview:
- Sequences one STEbus master transfer per Z180 memory or I/O access that the address decoder steers to the bus window.
- Drives the command code, the data strobe and the Z180 WAIT line.
- Ends the transfer on DATACK, TRFERR or a timeout.
- Keeps sticky error status readable by CPU glue logic; sits between the CPU pins and the STEbus buffers, next to the chip-select decoder.

Parameters:
SETUP_CYCLES, 1, clocks cm[2:0] is held valid before strobe falls (1..15)
TIMEOUT_CYCLES, 255, max clocks strobe stays low awaiting ack (1..255, 8-bit counter)
HOLD_CYCLES, 1, clocks cm[2:0] stays held after strobe rises (0..15)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-high
sel  in  1  STEbus window select from decoder, active-low
mreq  in  1  Z180 MREQ, active-low
iorq  in  1  Z180 IORQ, active-low
m1  in  1  Z180 M1, active-low
rd  in  1  Z180 RD, active-low
wr  in  1  Z180 WR, active-low
datack  in  1  STEbus DATACK, active-low, already synchronised
trferr  in  1  STEbus TRFERR, active-low, already synchronised
err_clr  in  1  clears sticky errors, active-high, one clock
cm  out  3  STEbus command {cm2,cm1,cm0}
strobe  out  1  STEbus DATSTB, active-low
zwait  out  1  Z180 WAIT, active-low
busy  out  1  high while not IDLE
err_trf  out  1  sticky: a transfer ended by TRFERR
err_to  out  1  sticky: a transfer ended by timeout

Behaviour:
- Reset values: cm=3'b000, strobe=1, zwait=1, busy=0, err_trf=0, err_to=0, state IDLE, counters 0. Reset applies immediately at any point in a transfer; strobe is released asynchronously.
- start = !sel & ((!mreq & (!rd | !wr)) | (!iorq & (!rd | !wr | !m1))).
- Command decode, latched on the start edge:
  - mem read 3'b111, mem write 3'b110
  - I/O read 3'b011, I/O write 3'b010
  - interrupt ack (!iorq & !m1) 3'b001
  - rd and wr both low: treat as read
- zwait (combinational) = 0 when (IDLE & start) or state in {SETUP, STROBE}; otherwise 1. WAIT must be valid in the same clock the request appears, so that the Z180 samples it in T2.
- FSM:
  - IDLE: on start, latch command, load setup counter -> SETUP.
  - SETUP: cm driven, strobe=1. After SETUP_CYCLES clocks -> STROBE, loading the timeout counter.
  - STROBE: strobe=0; counter decrements each clock.
    - trferr=0 -> set err_trf, go to RELEASE.
    - else datack=0 -> go to RELEASE.
    - else counter reaches 0 -> set err_to, go to RELEASE.
    - trferr and datack low in the same clock: trferr wins.
  - RELEASE: strobe=1, zwait=1; cm held for HOLD_CYCLES clocks (0 means 1 clock minimum in RELEASE) -> DONE.
  - DONE: cm=3'b000. Waits until mreq=1 and iorq=1 (CPU cycle finished) -> IDLE. This prevents a second transfer for the same CPU cycle.
- Abort: if start deasserts in SETUP or STROBE (CPU withdrew), go straight to DONE with strobe=1 and cm=000; no error flag is set.
- Error flags: set on the clock the terminating condition is seen. err_clr clears them; if set and clear coincide, set wins.
- busy=1 in all states except IDLE.
- Ack latency: zwait returns high exactly one clock after datack=0 is sampled in STROBE.

Test Plan:
- I/O read, SETUP=1, HOLD=1; sel=0, iorq=0, rd=0; datack=0 on the 3rd strobe clock:
  - cm=011 one clock before strobe falls
  - strobe low 3 clocks
  - zwait low from request until one clock after ack
  - cm=000 after the DONE state
  - no error flags
- Mem write, datack held 1, TIMEOUT=8:
  - strobe low exactly 8 clocks, then release
  - err_to=1, zwait released
  - err_clr pulse -> err_to=0
- Interrupt ack (iorq=0, m1=0) with trferr=0 and datack=0 in the same clock:
  - cm=001, err_trf=1, err_to=0
- CPU releases mreq during SETUP: strobe never falls, FSM returns to IDLE, no error; a new start then begins a fresh transfer.
- rst pulsed while strobe=0: strobe=1, zwait=1, cm=000, busy=0 immediately, without waiting for a clock.
- Request held after the ack with mreq=0 for 5 more clocks: only one strobe pulse; FSM stays in DONE until mreq=1.
